// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Memory geometry, FSM state encoding and the one-bit port index.
package dmem_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef logic port_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported memory.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          memwrite;
  logic          memread;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data;
  logic [DW-1:0] memory_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  memory_read_data,
    output ack0, rdata0, ack1, rdata1,
    output memwrite, memread, memory_address, memory_write_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output memory_read_data,
    input  ack0, rdata0, ack1, rdata1,
    input  memwrite, memread, memory_address, memory_write_data
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the port
// that was not granted last. The grant pointer itself lives in the caller.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic       any_grant,
  output port_t      winner
);

  always_comb begin
    any_grant = |req;
    winner    = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU port (0) and the debug port (1).
// One transaction per IDLE -> ACCESS -> RESP pass; every output comes straight from a flop.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  port_t         last_grant_q, last_grant_d;
  port_t         sel_q, sel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          memwrite_q, memwrite_d;
  logic          memread_q, memread_d;

  logic          any_grant;
  port_t         winner;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .any_grant  (any_grant),
    .winner     (winner)
  );

  always_comb begin
    win_we    = winner ? bus.we1    : bus.we0;
    win_addr  = winner ? bus.addr1  : bus.addr0;
    win_wdata = winner ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    memwrite_d   = 1'b0;
    memread_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_grant) begin
          // Fields are frozen here; later changes on the requester side are ignored.
          sel_d        = winner;
          last_grant_d = winner;
          we_d         = win_we;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
          memwrite_d   = win_we;
          memread_d    = ~win_we;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (sel_q) rdata1_d = bus.memory_read_data;
          else       rdata0_d = bus.memory_read_data;
        end
        ack0_d  = ~sel_q;
        ack1_d  = sel_q;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      memwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      memwrite_q   <= memwrite_d;
      memread_q    <= memread_d;
    end
  end

  // Address/data only move at grant, so they are stable across the strobe cycle.
  assign bus.memory_address    = addr_q;
  assign bus.memory_write_data = wdata_q;
  assign bus.memwrite          = memwrite_q;
  assign bus.memread           = memread_q;
  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.rdata0            = rdata0_q;
  assign bus.rdata1            = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a behavioural memory and a
// transaction-level reference model (memory image, last read per port, last served port).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_mem = 1'b1;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 32x5 memory: combinational read, level-sensitive write sampled on the edge.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (bus.memwrite) begin
      mem[bus.memory_address] <= bus.memory_write_data;
    end
  end
  assign bus.memory_read_data = mem[bus.memory_address];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rd [2];
  bit            last_served;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (!p) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic get_ack(input bit p);
    return p ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input bit p);
    return p ? bus.rdata1 : bus.rdata0;
  endfunction

  function automatic logic [23:0] all_outputs();
    return {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.memwrite, bus.memread,
            bus.memory_address, bus.memory_write_data};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (cycles) @(negedge clk);
    reset_n     = 1'b1;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    last_served = 1'b1;
  endtask

  // Called in the ack cycle of port p: apply the transaction to the model and compare.
  task automatic finish_port(input bit p, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    if (w) ref_mem[a] = d;
    else   exp_rd[p] = ref_mem[a];
    check("rdata", get_rdata(p), exp_rd[p]);
    if (w) check("mem_written", mem[a], ref_mem[a]);
    last_served = p;
    drive(p, 0, w, a, d);
  endtask

  // Lone request: strobe one cycle after the grant edge, ack one cycle later.
  task automatic single(input bit p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    drive(p, 1, w, a, d);
    @(negedge clk);
    check("strobe_memwrite", bus.memwrite, w);
    check("strobe_memread", bus.memread, !w);
    check("strobe_addr", bus.memory_address, a);
    check("no_ack_in_access", {bus.ack1, bus.ack0}, 0);
    @(negedge clk);
    check("ack", get_ack(p), 1);
    check("ack_other", get_ack(!p), 0);
    check("strobes_low_resp", {bus.memwrite, bus.memread}, 0);
    finish_port(p, w, a, d);
    @(negedge clk);
    check("ack_single_pulse", get_ack(p), 0);
  endtask

  // Both ports request together: the port not served last goes first, the other 3 cycles later.
  task automatic serve_both(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit first;
    logic e0, e1;
    first = ~last_served;
    drive(0, 1, w0, a0, d0);
    drive(1, 1, w1, a1, d1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e0 = (k == 2 && first == 1'b0) || (k == 5 && first == 1'b1);
      e1 = (k == 2 && first == 1'b1) || (k == 5 && first == 1'b0);
      check("both_ack0", bus.ack0, e0);
      check("both_ack1", bus.ack1, e1);
      check("strobe_exclusive", bus.memwrite & bus.memread, 0);
      if (e0) finish_port(0, w0, a0, d0);
      if (e1) finish_port(1, w1, a1, d1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          e0, e1, rw;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    int            mode;

    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    last_served = 1'b1;

    // Reset held for three cycles, then idle with no requests.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("outputs_in_reset", all_outputs(), 0);
    clear_mem = 1'b0;
    reset_n   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_outputs_zero", all_outputs(), 0);
    end

    // Port 0 write then read back.
    single(0, 1, 5'd11, 5'b00110);
    single(0, 0, 5'd11, 5'd0);

    // Preload for contention, then reset so port 0 wins the first tie.
    single(0, 1, 5'd3, 5'd7);
    single(0, 1, 5'd4, 5'd9);
    do_reset(2);

    // Contention with both requests held: acks alternate, port 0 first, 3 cycles apart.
    drive(0, 1, 0, 5'd3, 5'd0);
    drive(1, 1, 0, 5'd4, 5'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e0 = (k == 2) || (k == 8);
      e1 = (k == 5) || (k == 11);
      check("rr_ack0", bus.ack0, e0);
      check("rr_ack1", bus.ack1, e1);
      if (e0) check("rr_rdata0", bus.rdata0, 5'd7);
      if (e1) check("rr_rdata1", bus.rdata1, 5'd9);
      if (k == 11) begin
        drive(0, 0, 0, 5'd3, 5'd0);
        drive(1, 0, 0, 5'd4, 5'd0);
      end
    end
    exp_rd[0]   = ref_mem[3];
    exp_rd[1]   = ref_mem[4];
    last_served = 1'b1;

    // Port 1 write whose fields change after the grant.
    drive(1, 1, 1, 5'd2, 5'd21);
    @(negedge clk);
    check("late_change_memwrite", bus.memwrite, 1);
    drive(1, 1, 1, 5'd9, 5'd0);
    @(negedge clk);
    check("late_change_ack1", bus.ack1, 1);
    drive(1, 0, 1, 5'd9, 5'd0);
    ref_mem[2] = 5'd21;
    check("late_change_mem2", mem[2], 5'd21);
    check("late_change_mem9", mem[9], ref_mem[9]);
    last_served = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("late_change_ack1_once", bus.ack1, 0);
    end

    // Reset during the strobe cycle of a port 0 write.
    drive(0, 1, 1, 5'd20, 5'd13);
    @(negedge clk);
    check("midop_memwrite_high", bus.memwrite, 1);
    #1 reset_n = 1'b0;
    #1 check("midop_strobes_drop", {bus.memwrite, bus.memread}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 1, 5'd20, 5'd13);
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    last_served = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midop_no_ack", {bus.ack1, bus.ack0}, 0);
    end
    check("midop_mem20_untouched", mem[20], ref_mem[20]);
    single(1, 0, 5'd2, 5'd0);

    // A write leaves the port's read register alone.
    single(0, 0, 5'd3, 5'd0);
    single(0, 1, 5'd3, 5'd1);
    check("write_keeps_rdata0", bus.rdata0, 5'd7);
    single(0, 0, 5'd3, 5'd0);

    // Randomized mix of lone and contending transactions.
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      rw   = 1'($urandom_range(0, 1));
      ra0  = AW'($urandom_range(0, 31));
      rd0  = DW'($urandom_range(0, 31));
      ra1  = AW'($urandom_range(0, 31));
      rd1  = DW'($urandom_range(0, 31));
      if (mode == 0)      single(0, rw, ra0, rd0);
      else if (mode == 1) single(1, rw, ra1, rd1);
      else                serve_both(rw, ra0, rd0, 1'($urandom_range(0, 1)), ra1, rd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported 32x5 data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/loader port).
- Grants one access at a time, round-robin on contention.
- Drives the memory's level-sensitive memwrite/memread strobes for exactly one cycle per access.
- Captures read data into a register and returns it with a one-cycle ack pulse.

Parameters:
- AW, 5, memory address width (32 entries)
- DW, 5, memory data width

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- ack0  out  1  port 0 completion pulse, one cycle
- rdata0  out  DW  port 0 read data, valid while ack0=1 on a read
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- memwrite  out  1  to memory write strobe
- memread  out  1  to memory read strobe
- memory_address  out  AW  to memory address
- memory_write_data  out  DW  to memory write data
- memory_read_data  in  DW  from memory, combinational read data

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first contention.
  - All outputs 0: ack0/1, rdata0/1, memwrite, memread, memory_address, memory_write_data.
- Reset mid-transaction aborts it: no ack is issued and the memory strobes drop immediately.
- FSM states IDLE, ACCESS, RESP; one transaction every 3 cycles at most.
- IDLE:
  - If no req is high, stay in IDLE.
  - Else choose a winner: if only one req is high, that port wins. If both are high, the port != last_grant wins.
  - On the edge: latch the winner's we/addr/wdata into internal registers; sel <= winner; last_grant <= winner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - memory_address/memory_write_data are driven from the latched registers.
  - memwrite = latched we; memread = ~latched we.
  - On the edge: if read, capture memory_read_data into rdata[sel]. Go to RESP.
- RESP (exactly 1 cycle):
  - memwrite=memread=0. ack[sel]=1; the other ack stays 0.
  - On the edge go to IDLE.
- memwrite/memread are high only in ACCESS; never high in IDLE, RESP or reset.
- memory_address/memory_write_data hold their last registered values outside ACCESS, so there are no glitches.
- Latency: req sampled high at edge N in IDLE → strobe during cycle N+1 → ack during cycle N+2.
- A requester keeping req high after ack is re-arbitrated in the following IDLE cycle. Under contention the two ports alternate strictly, so the wait bound is 6 cycles.
- Requests and fields are latched at grant. Changing addr/wdata/we or dropping req after grant does not affect the transaction, and ack is still pulsed.
- rdataX holds its last captured value until the next read for that port. A write does not update rdataX.
- ackX is never high for two consecutive cycles.

Decomposition:
- Package dmem_pkg holds:
  - AW=5, DW=5 constants
  - state typedef {IDLE, ACCESS, RESP}
  - port index typedef (1 bit)
- Sub-module rr_arb2:
  - inputs: req[1:0], last_grant
  - outputs: any_grant, winner
  - purely combinational; the pointer register stays in dmem_arbiter.
- The bench provides a behavioural 32x5 memory model with a combinational read.

Test Plan:
- Reset then idle: reset_n low 3 cycles, then high with no reqs → all outputs 0 for 10 cycles; memwrite/memread never asserted.
- Single write then read, port 0:
  - Write: req0=1, we0=1, addr0=5'd11, wdata0=5'b00110 → memwrite=1 exactly in cycle 2, ack0 in cycle 3.
  - Read: req0=1, we0=0, addr0=11 → memread=1 for one cycle, ack0=1 with rdata0=5'b00110.
- Contention round-robin:
  - Set req0 and req1 high together, held continuously, both reads; mem[3]=5'd7, mem[4]=5'd9; addr0=3, addr1=4.
  - Acks alternate ack0, ack1, ack0, ack1, each 3 cycles apart; rdata0=7, rdata1=9.
  - First grant goes to port 0 after reset.
- Field change after grant: start port-1 write addr=2, data=5'd21; in the ACCESS cycle change addr1=9, wdata1=0 → mem[2]=21, mem[9] unchanged, ack1 pulsed once.
- Reset mid-op: assert reset_n=0 during ACCESS of a port-0 write → memwrite drops asynchronously; no ack0 after release; FSM accepts a new req1 normally.
- Write does not disturb rdata: port-0 read of 7 from addr 3, then port-0 write 5'd1 to addr 3 → rdata0 remains 7; a subsequent read returns 1.
